// File: rtl/pixel_collector_pkg.sv
// Shared types for the pixel collector: the buffered pixel entry and frame-size default.
package pixel_collector_pkg;

  localparam int PIXEL_ID_W         = 20;
  localparam int COLOR_W            = 24;
  localparam int NUM_PIXELS_DEFAULT = 307200;

  typedef struct packed {
    logic [PIXEL_ID_W-1:0] pixel_id;
    logic [COLOR_W-1:0]    color;
  } pixel_buffer_entry_t;

  localparam int ENTRY_W = $bits(pixel_buffer_entry_t);

endpackage

// File: rtl/pixel_collector_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the rotating pointer.
module rr_arbiter #(
  parameter int NUM_CH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [NUM_CH-1:0] grant
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_next;
  logic [PTR_W-1:0] idx;

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int offs);
    int sum;
    sum = int'(base) + offs;
    if (sum >= NUM_CH) sum = sum - NUM_CH;
    return PTR_W'(sum);
  endfunction

  // Scanning from the farthest offset down lets the nearest requester overwrite the others.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    grant    = '0;
    ptr_next = ptr;
    idx      = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = wrap_add(ptr, k);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        ptr_next   = wrap_add(idx, 1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/pixel_collector.sv
// Merges several upstream pixel channels into one in-order buffer and counts popped pixels per frame.
module pixel_collector
  import pixel_collector_pkg::*;
#(
  parameter int NUM_CH     = 3,
  parameter int DEPTH      = 200,
  parameter int NUM_PIXELS = NUM_PIXELS_DEFAULT
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_CH-1:0]                valid_us,
  input  logic [NUM_CH*ENTRY_W-1:0]        data_us,
  output logic [NUM_CH-1:0]                stall_us,
  input  logic                             re,
  output pixel_buffer_entry_t              data_out,
  output logic                             empty,
  output logic [$clog2(DEPTH+1)-1:0]       num_used,
  output logic [$clog2(NUM_PIXELS+1)-1:0]  pix_cnt,
  output logic                             frame_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(NUM_PIXELS + 1);

  localparam logic [AW-1:0] LAST_SLOT = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PIX  = PW'(NUM_PIXELS - 1);

  logic [NUM_CH-1:0]   grant;
  logic                full;
  logic                wr_en;
  logic                rd_en;
  pixel_buffer_entry_t wr_data;
  pixel_buffer_entry_t mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;

  function automatic logic [AW-1:0] next_slot(input logic [AW-1:0] slot);
    return (slot == LAST_SLOT) ? '0 : slot + 1'b1;
  endfunction

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (valid_us),
    .advance (wr_en),
    .grant   (grant)
  );

  assign full  = (num_used == FULL_CNT);
  assign empty = (num_used == '0);

  // Reset forces every channel to stall so nothing is accepted while the buffer is being cleared.
  assign stall_us = ~grant | {NUM_CH{full | rst}};
  assign wr_en    = |(valid_us & ~stall_us);
  assign rd_en    = re & ~empty;
  assign data_out = mem[rd_ptr];

  always_comb begin
    wr_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) wr_data = data_us[i*ENTRY_W +: ENTRY_W];
    end
  end

  // NOTE: storage is not reset; occupancy and pointers define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      num_used   <= '0;
      pix_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (wr_en) wr_ptr <= next_slot(wr_ptr);
      if (rd_en) begin
        rd_ptr <= next_slot(rd_ptr);
        if (pix_cnt == LAST_PIX) begin
          pix_cnt    <= '0;
          frame_done <= 1'b1;
        end else begin
          pix_cnt <= pix_cnt + 1'b1;
        end
      end
      case ({wr_en, rd_en})
        2'b10:   num_used <= num_used + 1'b1;
        2'b01:   num_used <= num_used - 1'b1;
        default: num_used <= num_used;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_collector.sv
// Drives two collectors (shallow and deep buffer) with shared stimulus and checks them against a queue model.
module tb_pixel_collector;
  import pixel_collector_pkg::*;

  localparam int NCH     = 3;
  localparam int NPIX    = 10;
  localparam int DEPTH_A = 4;
  localparam int DEPTH_B = 32;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NCH-1:0]           valid_us;
  logic [NCH*ENTRY_W-1:0]   data_us;
  logic                     re;

  logic [NCH-1:0]                 stall_a, stall_b;
  pixel_buffer_entry_t            dout_a, dout_b;
  logic                           empty_a, empty_b;
  logic [$clog2(DEPTH_A+1)-1:0]   used_a;
  logic [$clog2(DEPTH_B+1)-1:0]   used_b;
  logic [$clog2(NPIX+1)-1:0]      pix_a, pix_b;
  logic                           fd_a, fd_b;

  always #5 clk = ~clk;

  pixel_collector #(.NUM_CH(NCH), .DEPTH(DEPTH_A), .NUM_PIXELS(NPIX)) dut_a (
    .clk(clk), .rst(rst), .valid_us(valid_us), .data_us(data_us), .stall_us(stall_a),
    .re(re), .data_out(dout_a), .empty(empty_a), .num_used(used_a), .pix_cnt(pix_a),
    .frame_done(fd_a)
  );

  pixel_collector #(.NUM_CH(NCH), .DEPTH(DEPTH_B), .NUM_PIXELS(NPIX)) dut_b (
    .clk(clk), .rst(rst), .valid_us(valid_us), .data_us(data_us), .stall_us(stall_b),
    .re(re), .data_out(dout_b), .empty(empty_b), .num_used(used_b), .pix_cnt(pix_b),
    .frame_done(fd_b)
  );

  // Reference model: one FIFO queue, arbitration pointer and pixel counter per instance.
  pixel_buffer_entry_t mq [2][$];
  int  mptr [2];
  int  mpix [2];
  bit  mfd  [2];
  int  depth [2] = '{DEPTH_A, DEPTH_B};
  int  pend_g [2];
  bit  pend_w [2];
  bit  pend_p [2];
  int  acc_ch [2];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mq[d].delete();
      mptr[d] = 0;
      mpix[d] = 0;
      mfd[d]  = 1'b0;
      pend_w[d] = 1'b0;
      pend_p[d] = 1'b0;
    end
  endtask

  task automatic rand_data();
    pixel_buffer_entry_t e;
    for (int c = 0; c < NCH; c++) begin
      e.pixel_id = PIXEL_ID_W'($urandom);
      e.color    = COLOR_W'($urandom);
      data_us[c*ENTRY_W +: ENTRY_W] = e;
    end
  endtask

  task automatic compare_dut(input int d);
    logic [NCH-1:0]      st;
    logic                em, fd;
    int                  used, pc, g;
    pixel_buffer_entry_t dout;
    logic [NCH-1:0]      exp_st;
    bit                  full;
    string               nm;
    nm = (d == 0) ? "a" : "b";
    if (d == 0) begin
      st = stall_a; em = empty_a; used = int'(used_a); pc = int'(pix_a); fd = fd_a; dout = dout_a;
    end else begin
      st = stall_b; em = empty_b; used = int'(used_b); pc = int'(pix_b); fd = fd_b; dout = dout_b;
    end
    full = (mq[d].size() == depth[d]);
    g = -1;
    if (!rst) begin
      for (int k = 0; k < NCH; k++) begin
        if (g < 0 && valid_us[(mptr[d] + k) % NCH]) g = (mptr[d] + k) % NCH;
      end
    end
    exp_st = '1;
    if (g >= 0 && !full && !rst) exp_st[g] = 1'b0;
    pend_g[d] = g;
    pend_w[d] = (g >= 0) && !full && !rst;
    pend_p[d] = re && (mq[d].size() > 0) && !rst;
    acc_ch[d] = -1;
    for (int i = NCH - 1; i >= 0; i--) if (valid_us[i] && !st[i]) acc_ch[d] = i;

    check({nm, "_stall"},   64'(st),   64'(exp_st));
    check({nm, "_empty"},   64'(em),   64'(mq[d].size() == 0));
    check({nm, "_used"},    64'(used), 64'(mq[d].size()));
    check({nm, "_pix_cnt"}, 64'(pc),   64'(mpix[d]));
    check({nm, "_frame"},   64'(fd),   64'(mfd[d]));
    if (mq[d].size() > 0) check({nm, "_data"}, 64'(dout), 64'(mq[d][0]));
  endtask

  task automatic advance_model(input int d);
    mfd[d] = 1'b0;
    if (pend_p[d]) begin
      mq[d].delete(0);
      mpix[d]++;
      if (mpix[d] == NPIX) begin
        mpix[d] = 0;
        mfd[d]  = 1'b1;
      end
    end
    if (pend_w[d]) begin
      mq[d].push_back(pixel_buffer_entry_t'(data_us[pend_g[d]*ENTRY_W +: ENTRY_W]));
      mptr[d] = (pend_g[d] + 1) % NCH;
    end
  endtask

  // One clock cycle: compare settled outputs, then let the edge happen and update the model.
  task automatic step();
    #1;
    compare_dut(0);
    compare_dut(1);
    @(posedge clk);
    if (rst) model_reset();
    else begin
      advance_model(0);
      advance_model(1);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    step();
    step();
    rst = 1'b0;
  endtask

  int exp_order [6];
  int pops;

  initial begin
    rst = 1'b1; valid_us = '0; re = 1'b0; data_us = '0;
    model_reset();
    @(negedge clk);
    valid_us = 3'b101;
    do_reset();

    // All channels valid for six cycles into an empty buffer.
    exp_order = '{0, 1, 2, 0, 1, 2};
    valid_us = '1;
    for (int i = 0; i < 6; i++) begin
      rand_data();
      step();
      check("order_all_valid", 64'(acc_ch[1]), 64'(exp_order[i]));
    end
    check("used_after_six", 64'(used_b), 64'd6);
    check("used_sat_shallow", 64'(used_a), 64'd4);

    // Only channel 2 for three cycles, then all channels.
    valid_us = '0;
    do_reset();
    exp_order = '{2, 2, 2, 0, 1, 2};
    for (int i = 0; i < 6; i++) begin
      valid_us = (i < 3) ? 3'b100 : 3'b111;
      rand_data();
      step();
      check("order_ch2_first", 64'(acc_ch[1]), 64'(exp_order[i]));
    end

    // Shallow buffer saturates, one pop frees a slot that refills on the next cycle.
    do_reset();
    valid_us = '1;
    for (int i = 0; i < 6; i++) begin rand_data(); step(); end
    #1;
    check("full_used", 64'(used_a), 64'd4);
    check("full_stall", 64'(stall_a), 64'(3'b111));
    re = 1'b1;
    step();
    check("full_pop_no_write", 64'(acc_ch[0]), -64'sd1);
    check("full_after_pop", 64'(used_a), 64'd3);
    re = 1'b0;
    step();
    check("full_refill", 64'(used_a), 64'd4);

    // Single write with re held: visible and popped one cycle later.
    valid_us = '0;
    do_reset();
    re = 1'b1;
    valid_us = 3'b001;
    data_us[0 +: ENTRY_W] = {PIXEL_ID_W'(5), COLOR_W'(24'h00abcd)};
    step();
    valid_us = '0;
    check("wr2rd_empty", 64'(empty_b), 64'd0);
    check("wr2rd_pixel_id", 64'(dout_b.pixel_id), 64'd5);
    step();
    check("wr2rd_popped", 64'(empty_b), 64'd1);
    re = 1'b0;

    // 25 writes then 25 pops: frame pulses after pops 10 and 20.
    do_reset();
    valid_us = 3'b010;
    for (int i = 0; i < 25; i++) begin rand_data(); step(); end
    check("frame_fill", 64'(used_b), 64'd25);
    valid_us = '0;
    re = 1'b1;
    for (pops = 1; pops <= 25; pops++) begin
      step();
      check("frame_pulse", 64'(fd_b), 64'(pops == 10 || pops == 20));
    end
    check("frame_final_pix", 64'(pix_b), 64'd5);

    // Reset mid-frame with three entries buffered and pix_cnt at 7.
    re = 1'b0;
    valid_us = 3'b001;
    for (int i = 0; i < 5; i++) begin rand_data(); step(); end
    valid_us = '0;
    re = 1'b1;
    step();
    step();
    re = 1'b0;
    check("pre_rst_used", 64'(used_b), 64'd3);
    check("pre_rst_pix", 64'(pix_b), 64'd7);
    valid_us = '1;
    rst = 1'b1;
    #1;
    check("rst_empty", 64'(empty_b), 64'd1);
    check("rst_pix", 64'(pix_b), 64'd0);
    check("rst_frame", 64'(fd_b), 64'd0);
    model_reset();
    step();
    rst = 1'b0;
    step();
    check("rst_next_grant", 64'(acc_ch[1]), 64'd0);

    // Random traffic: fill-biased then drain-biased, with occasional resets.
    for (int i = 0; i < 400; i++) begin
      valid_us = NCH'($urandom);
      rand_data();
      re = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 63) == 0) begin
        rst = 1'b1;
        model_reset();
        step();
        rst = 1'b0;
      end else begin
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
